display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
- Time-multiplexed scan controller for the vending machine's four 7-segment digits.
- Holds a 4-digit BCD shadow value and scans the digits one at a time through the one-hot `displays` strobe, with a dead-time blank between digits to prevent ghosting.
- Drives the decoded segment pattern for the active digit and supports leading-zero suppression.
- Takes new values through a load/ack handshake and applies them only at frame boundaries, so a frame never shows mixed old and new digits.

Parameters:
- PRESCALE, 50000: clk cycles per digit slot (blank plus show). Must be ≥ 2.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot, with all digits off. Must be ≥ 1 and < PRESCALE.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run scanning. Sampled at frame boundaries and in IDLE.
- digits_in  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- load  input  1  request to capture digits_in. Held high until load_ack.
- load_ack  output  1  one-cycle pulse: digits_in has been captured into the pending register.
- lz_blank  input  1  enable leading-zero suppression.
- displays  output  4  one-hot digit strobe; bit k drives digit k.
- segments  output  7  {g,f,e,d,c,b,a}, active-high.
- frame_done  output  1  one-cycle pulse at the end of each digit-3 slot.

Behaviour:
- Reset (async): takes effect immediately, even mid-slot.
  - State = IDLE, idx = 0, slot counter = 0.
  - shadow = 0, pending = 0, pending_valid = 0.
  - displays, segments, load_ack and frame_done are all 0.
- All outputs are registered.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - displays = 0, segments = 0.
  - If pending_valid, then shadow ← pending and pending_valid ← 0.
  - When enable = 1: next state BLANK, idx = 0, counter = 0.
- BLANK:
  - displays = 0, segments = 0.
  - Counter increments; when counter = BLANK_CYCLES−1, next state is SHOW.
- SHOW:
  - displays = 1 << idx, segments = decode(shadow nibble idx), unless suppressed.
  - Counter continues; when counter = PRESCALE−1, the slot ends and the counter returns to 0.
  - Slot end, idx < 3: idx ← idx+1, next state BLANK.
  - Slot end, idx = 3 (frame boundary):
    - frame_done = 1 for exactly that one cycle.
    - If pending_valid: shadow ← pending, pending_valid ← 0.
    - idx ← 0; next state BLANK if enable = 1, else IDLE.
- Timing from enable sampled high on edge E:
  - displays is 0001 from E+BLANK_CYCLES through E+PRESCALE−1.
  - Each slot lasts exactly PRESCALE cycles; a frame lasts 4·PRESCALE cycles.
- enable dropped mid-frame: the current frame completes (including frame_done), then the block goes to IDLE.
- Decode:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Nibbles A–F → 40 (dash).
- Leading-zero suppression (lz_blank = 1, evaluated on shadow):
  - Digit k (k = 3, 2, 1) is suppressed if nibbles k..3 are all zero. Digit 0 is never suppressed.
  - A suppressed slot keeps its timing, but displays = 0 and segments = 0 for the whole slot.
- Load handshake:
  - If load = 1 and pending_valid = 0 on an edge: pending ← digits_in, pending_valid ← 1, and load_ack = 1 during the following cycle.
  - If pending_valid = 1, load waits without ack.
  - If a frame boundary coincides with load = 1 while pending_valid = 1: the transfer happens on that edge, and the capture happens on the next edge, with ack the cycle after.
  - load_ack never stays high for two consecutive cycles. The requester must drop load in the ack cycle.
- A shadow change never occurs mid-frame while scanning.

Test Plan:
All tests use PRESCALE = 8, BLANK_CYCLES = 2.
1. Reset behaviour: enable = 1 and shadow = 0; reset pulses while displays = 0100 → same cycle: displays = 0, segments = 0, frame_done = 0. After release with enable = 1, the scan restarts at digit 0 after 2 blank cycles.
2. Scan sequence: enable = 1, shadow = 0, lz_blank = 0 → displays sequence is 0000×2, 0001×6, 0000×2, 0010×6, 0000×2, 0100×6, 0000×2, 1000×6, repeating. segments = 3F whenever displays ≠ 0. frame_done pulses once every 32 cycles.
3. Frame-boundary update: while scanning, load with 16'h1234 → load_ack one cycle later. The current frame still shows 0s. After frame_done: digit0 = 66, digit1 = 4F, digit2 = 5B, digit3 = 06.
4. Back-to-back loads: load 16'h1111 is acked; then load 16'h2222 is held → no ack until the frame boundary, ack two cycles after the boundary. The next frame shows 1s, the frame after shows 2s.
5. Leading-zero suppression: lz_blank = 1, shadow 16'h0050 → displays never equals 1000 or 0100; digit1 = 6D, digit0 = 3F. With shadow 16'h0000, only digit 0 lights, showing 3F.
6. Non-BCD nibble and enable drop: shadow 16'h00A0 with lz_blank = 0 → digit1 shows 40. Dropping enable during digit 1 → frame completes, frame_done pulses, then displays stays 0 in IDLE.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// Bundles the display controller's control, load handshake and display-drive signals.
// The master side drives value/control inputs; the slave side is the scan controller.
interface display_scan_controller_if;
  logic        enable;
  logic [15:0] digits_in;
  logic        load;
  logic        load_ack;
  logic        lz_blank;
  logic [3:0]  displays;
  logic [6:0]  segments;
  logic        frame_done;

  modport master (
    output enable, digits_in, load, lz_blank,
    input  load_ack, displays, segments, frame_done
  );

  modport slave (
    input  enable, digits_in, load, lz_blank,
    output load_ack, displays, segments, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with blanking dead time, leading-zero
// suppression and a pending/shadow value pair that only swaps at frame boundaries.
module display_scan_controller #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  display_scan_controller_if.slave   bus
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   shadow_reg;
  logic [15:0]   pending_reg;
  logic          pending_valid_reg;
  logic          load_ack_reg;
  logic          frame_done_reg;
  logic [3:0]    displays_reg;
  logic [6:0]    segments_reg;

  logic [3:1]    lead_zero;
  logic [3:0]    suppress;
  logic [3:0]    cur_nibble;
  logic          blank_end;
  logic          slot_end;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // lead_zero[k]: nibbles k..3 of the shadow value are all zero
  assign lead_zero[3] = (shadow_reg[15:12] == 4'd0);
  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_lead_zero
      assign lead_zero[gi] = lead_zero[gi+1] && (shadow_reg[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  assign suppress   = {lead_zero[3:1], 1'b0} & {4{bus.lz_blank}};
  assign cur_nibble = shadow_reg[{idx_reg, 2'b00} +: 4];
  assign blank_end  = (count_reg == CW'(BLANK_CYCLES - 1));
  assign slot_end   = (count_reg == CW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      count_reg         <= '0;
      idx_reg           <= '0;
      shadow_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      load_ack_reg      <= 1'b0;
      frame_done_reg    <= 1'b0;
      displays_reg      <= '0;
      segments_reg      <= '0;
    end else begin
      load_ack_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      displays_reg   <= '0;
      segments_reg   <= '0;

      // Capture looks at pending_valid before any transfer on this edge, so a
      // request colliding with a transfer is taken one edge later.
      if (bus.load && !pending_valid_reg) begin
        pending_reg       <= bus.digits_in;
        pending_valid_reg <= 1'b1;
        load_ack_reg      <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pending_valid_reg) begin
            shadow_reg        <= pending_reg;
            pending_valid_reg <= 1'b0;
          end
          idx_reg   <= '0;
          count_reg <= '0;
          if (bus.enable) state_reg <= BLANK;
        end

        BLANK: begin
          count_reg <= count_reg + CW'(1);
          if (blank_end) begin
            state_reg <= SHOW;
            if (!suppress[idx_reg]) begin
              displays_reg <= 4'b0001 << idx_reg;
              segments_reg <= seg_decode(cur_nibble);
            end
          end
        end

        SHOW: begin
          if (slot_end) begin
            count_reg <= '0;
            if (idx_reg == 2'd3) begin
              frame_done_reg <= 1'b1;
              if (pending_valid_reg) begin
                shadow_reg        <= pending_reg;
                pending_valid_reg <= 1'b0;
              end
              idx_reg   <= '0;
              state_reg <= bus.enable ? BLANK : IDLE;
            end else begin
              idx_reg   <= idx_reg + 2'd1;
              state_reg <= BLANK;
            end
          end else begin
            count_reg <= count_reg + CW'(1);
            if (!suppress[idx_reg]) begin
              displays_reg <= 4'b0001 << idx_reg;
              segments_reg <= seg_decode(cur_nibble);
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.load_ack   = load_ack_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.displays   = displays_reg;
  assign bus.segments   = segments_reg;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (PRESCALE=8, BLANK_CYCLES=2): per-slot
// expectations are queued when a value is scheduled and compared as frames scan out.
module tb_display_scan_controller;
  localparam int P = 8;
  localparam int B = 2;

  logic clk;
  logic reset;
  display_scan_controller_if bus();

  display_scan_controller #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] disp;
    logic [6:0] seg;
  } slot_t;

  slot_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (n > 4'd9) return 7'h40;
    return tab[n];
  endfunction

  // Digit k>0 goes dark when lz is on and the value shifted down by k digits is zero.
  task automatic push_frame(input logic [15:0] value, input logic lz);
    slot_t s;
    for (int k = 0; k < 4; k++) begin
      if (lz && k > 0 && ((value >> (4 * k)) == 16'd0)) begin
        s.disp = 4'd0;
        s.seg  = 7'd0;
      end else begin
        s.disp = 4'(1 << k);
        s.seg  = ref_seg(value[4*k +: 4]);
      end
      exp_q.push_back(s);
    end
  endtask

  // Starts on the sample where frame_done is high; ends on the next such sample.
  task automatic run_frame(input string tag);
    slot_t e [4];
    logic [3:0] ed;
    logic [6:0] es;
    chk({tag, "_queue"}, 16'(exp_q.size() >= 4), 16'd1);
    for (int k = 0; k < 4; k++) e[k] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int j = 0; j < 4 * P; j++) begin
      if (j > 0) tick();
      ed = ((j % P) < B) ? 4'd0 : e[j / P].disp;
      es = ((j % P) < B) ? 7'd0 : e[j / P].seg;
      chk({tag, "_displays"}, 16'(bus.displays), 16'(ed));
      chk({tag, "_segments"}, 16'(bus.segments), 16'(es));
      chk({tag, "_frame_done"}, 16'(bus.frame_done), 16'(j == 0));
    end
    tick();
    $display("frame %s: digits %h %h %h %h", tag, e[3].seg, e[2].seg, e[1].seg, e[0].seg);
  endtask

  task automatic do_load(input logic [15:0] d, input int exp_wait);
    int n;
    n = 0;
    bus.digits_in = d;
    bus.load      = 1'b1;
    do begin
      tick();
      n++;
    end while (bus.load_ack !== 1'b1 && n < 200);
    chk("ack_wait", 16'(n), 16'(exp_wait));
    bus.load = 1'b0;
    tick();
    chk("ack_single", 16'(bus.load_ack), 16'd0);
    $display("load %h acked after %0d cycles", d, n);
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("boundary_seen", 16'(bus.frame_done), 16'd1);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 16'd0;
    bus.lz_blank  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_displays", 16'(bus.displays), 16'd0);
    chk("rst_segments", 16'(bus.segments), 16'd0);
    chk("rst_load_ack", 16'(bus.load_ack), 16'd0);
    chk("rst_frame_done", 16'(bus.frame_done), 16'd0);
    reset      = 1'b0;
    bus.enable = 1'b1;

    n = 0;
    while (bus.displays !== 4'b0001 && n < 20) begin tick(); n++; end
    chk("first_show_latency", 16'(n), 16'd3);

    // Asynchronous reset in the middle of the digit-2 slot
    n = 0;
    while (bus.displays !== 4'b0100 && n < 200) begin tick(); n++; end
    chk("reach_digit2", 16'(bus.displays), 16'b0100);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_displays", 16'(bus.displays), 16'd0);
    chk("async_rst_segments", 16'(bus.segments), 16'd0);
    chk("async_rst_frame_done", 16'(bus.frame_done), 16'd0);
    tick();
    reset = 1'b0;
    n = 0;
    while (bus.displays === 4'd0 && n < 20) begin tick(); n++; end
    chk("restart_latency", 16'(n), 16'd3);
    chk("restart_displays", 16'(bus.displays), 16'b0001);
    chk("restart_segments", 16'(bus.segments), 16'h3F);

    // Plain scanning of zeros
    wait_boundary();
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0000, 1'b0);
    run_frame("scan0");
    run_frame("scan1");

    // Load mid-frame; the new value appears only from the next frame
    push_frame(16'h0000, 1'b0);
    push_frame(16'h1234, 1'b0);
    fork
      begin run_frame("upd_old"); run_frame("upd_new"); end
      do_load(16'h1234, 1);
    join

    // Back-to-back loads: second one waits for the boundary transfer
    push_frame(16'h1234, 1'b0);
    push_frame(16'h1111, 1'b0);
    push_frame(16'h2222, 1'b0);
    fork
      begin run_frame("b2b_1234"); run_frame("b2b_1111"); run_frame("b2b_2222"); end
      begin do_load(16'h1111, 1); do_load(16'h2222, 4 * P - 1); end
    join

    // Leading-zero suppression
    bus.lz_blank = 1'b1;
    push_frame(16'h2222, 1'b1);
    push_frame(16'h0050, 1'b1);
    push_frame(16'h0000, 1'b1);
    fork
      begin run_frame("lz_2222"); run_frame("lz_0050"); run_frame("lz_0000"); end
      begin do_load(16'h0050, 1); do_load(16'h0000, 4 * P - 1); end
    join

    // Non-BCD nibble, then enable dropped during digit 1
    bus.lz_blank = 1'b0;
    push_frame(16'h0000, 1'b0);
    push_frame(16'h00A0, 1'b0);
    fork
      begin run_frame("nb_0000"); run_frame("nb_00A0"); end
      begin
        do_load(16'h00A0, 1);
        repeat (4 * P + P + 3 - 2) tick();
        bus.enable = 1'b0;
      end
    join
    chk("final_frame_done", 16'(bus.frame_done), 16'd1);
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      chk("idle_displays", 16'(bus.displays), 16'd0);
      chk("idle_segments", 16'(bus.segments), 16'd0);
      chk("idle_frame_done", 16'(bus.frame_done), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
